seg_led_scan595: RTL and testbench

// - Parametrised multiplexed 7-segment driver for 1..8 digits behind a chained 74HC595 pair.
// - Shifts a 16-bit word {seg[7:0], com[7:0]} per digit, strobes it, holds it, then moves to the next digit.
// - Per-digit hex/raw mode, decimal point and blanking.
// - Sits beside the PIO output register in the top level and replaces the fixed 4-digit hex driver.

---
 rtl/seg_led_pkg.sv | 46 ++++
 rtl/seg_hex_font.sv | 17 +
 rtl/seg_led_scan595.sv | 189 ++++++++++++++++++
 tb/tb_seg_led_scan595.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_led_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_led_pkg
// Description : Shared types and the hex font for the 7-segment 595 drivers.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_led_pkg;

    localparam int c_word_w = 16;

    typedef enum logic [2:0] {
        ST_LOAD     = 3'd0,
        ST_SHIFT_LO = 3'd1,
        ST_SHIFT_HI = 3'd2,
        ST_STROBE   = 3'd3,
        ST_HOLD     = 3'd4
    } state_t;

    // Segment order {g,f,e,d,c,b,a}, active-high
    function automatic logic [6:0] hex_font(input logic [3:0] nib);
        logic [6:0] seg;
        seg = 7'h00;
        case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_hex_font.sv
`default_nettype none
// ============================================================================
// Module      : seg_hex_font
// Description : Combinational nibble to {g..a} segment pattern.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_hex_font
    import seg_led_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = hex_font(i_nibble);

endmodule
`default_nettype wire

// File: rtl/seg_led_scan595.sv
`default_nettype none
// ============================================================================
// Module      : seg_led_scan595
// Description : Multiplexed 1..8 digit 7-segment scanner driving a 74HC595 pair.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_led_scan595
    import seg_led_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int CLK_DIV        = 8,
    parameter int SCAN_HOLD      = 1000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit COM_ACTIVE_LOW = 1'b1
)(
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic [DIGITS*8-1:0]   digit_val,
    input  logic [DIGITS-1:0]     raw_mode,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank,
    output logic                  seg_clk,
    output logic                  seg_dat,
    output logic                  seg_str,
    output logic                  frame_done
);

    localparam int c_dig_w  = (DIGITS > 1)    ? $clog2(DIGITS)    : 1;
    localparam int c_div_w  = (CLK_DIV > 1)   ? $clog2(CLK_DIV)   : 1;
    localparam int c_hold_w = (SCAN_HOLD > 1) ? $clog2(SCAN_HOLD) : 1;

    localparam logic [c_dig_w-1:0]  c_dig_last  = c_dig_w'(DIGITS - 1);
    localparam logic [c_div_w-1:0]  c_div_last  = c_div_w'(CLK_DIV - 1);
    localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'((SCAN_HOLD > 0) ? SCAN_HOLD - 1 : 0);

    state_t                r_state;
    state_t                w_next_state;
    logic [c_div_w-1:0]    r_div_cnt;
    logic [3:0]            r_bit_cnt;
    logic [c_hold_w-1:0]   r_hold_cnt;
    logic [c_dig_w-1:0]    r_digit;
    logic [c_word_w-2:0]   r_shift;
    logic                  r_seg_clk;
    logic                  r_seg_dat;
    logic                  r_seg_str;
    logic                  r_frame_done;

    logic [7:0]            w_byte;
    logic                  w_raw;
    logic                  w_dp;
    logic                  w_blank;
    logic [6:0]            w_font;
    logic [7:0]            w_seg;
    logic [7:0]            w_com;
    logic [c_word_w-1:0]   w_word;
    logic                  w_div_done;
    logic                  w_last_bit;
    logic                  w_hold_done;
    logic                  w_div_state;
    logic                  w_digit_adv;

    // Only the current digit's inputs are looked at, so a digit can never be torn
    always_comb begin
        w_byte  = 8'h00;
        w_raw   = 1'b0;
        w_dp    = 1'b0;
        w_blank = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_digit == c_dig_w'(i)) begin
                w_byte  = digit_val[i*8 +: 8];
                w_raw   = raw_mode[i];
                w_dp    = dp[i];
                w_blank = blank[i];
            end
        end
    end

    seg_hex_font u_font (
        .i_nibble (w_byte[3:0]),
        .o_seg    (w_font)
    );

    always_comb begin
        w_seg = w_raw ? w_byte : {w_dp, w_font};
        if (w_blank) begin
            w_seg = 8'h00;
        end
        w_com  = 8'b1 << r_digit;
        w_word = {(SEG_ACTIVE_LOW ? ~w_seg : w_seg), (COM_ACTIVE_LOW ? ~w_com : w_com)};
    end

    assign w_div_done  = (r_div_cnt == c_div_last);
    assign w_last_bit  = (r_bit_cnt == 4'd15);
    assign w_hold_done = (r_hold_cnt == c_hold_last);
    assign w_div_state = (r_state == ST_SHIFT_LO) || (r_state == ST_SHIFT_HI) || (r_state == ST_STROBE);

    always_comb begin
        w_next_state = r_state;
        w_digit_adv  = 1'b0;
        case (r_state)
            ST_LOAD: begin
                w_next_state = ST_SHIFT_LO;
            end
            ST_SHIFT_LO: begin
                if (w_div_done) w_next_state = ST_SHIFT_HI;
            end
            ST_SHIFT_HI: begin
                if (w_div_done) w_next_state = w_last_bit ? ST_STROBE : ST_SHIFT_LO;
            end
            ST_STROBE: begin
                if (w_div_done) begin
                    if (SCAN_HOLD == 0) begin
                        w_next_state = ST_LOAD;
                        w_digit_adv  = 1'b1;
                    end else begin
                        w_next_state = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (w_hold_done) begin
                    w_next_state = ST_LOAD;
                    w_digit_adv  = 1'b1;
                end
            end
            default: begin
                w_next_state = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state      <= ST_LOAD;
            r_div_cnt    <= '0;
            r_bit_cnt    <= '0;
            r_hold_cnt   <= '0;
            r_digit      <= '0;
            r_shift      <= '0;
            r_seg_clk    <= 1'b0;
            r_seg_dat    <= 1'b0;
            r_seg_str    <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_seg_clk    <= (w_next_state == ST_SHIFT_HI);
            r_seg_str    <= (w_next_state == ST_STROBE);
            r_frame_done <= w_digit_adv && (r_digit == c_dig_last);

            if ((w_next_state != r_state) || !w_div_state) begin
                r_div_cnt <= '0;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end

            if ((r_state == ST_HOLD) && !w_hold_done) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end else begin
                r_hold_cnt <= '0;
            end

            // Data only moves when entering SHIFT_LO, keeping it stable across the 595 rising edge
            if (r_state == ST_LOAD) begin
                r_bit_cnt <= '0;
                r_shift   <= w_word[c_word_w-2:0];
                r_seg_dat <= w_word[c_word_w-1];
            end else if ((r_state == ST_SHIFT_HI) && w_div_done) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
                if (w_last_bit) begin
                    r_seg_dat <= 1'b0;
                end else begin
                    r_seg_dat <= r_shift[c_word_w-2];
                    r_shift   <= {r_shift[c_word_w-3:0], 1'b0};
                end
            end

            if (w_digit_adv) begin
                r_digit <= (r_digit == c_dig_last) ? '0 : r_digit + 1'b1;
            end
        end
    end

    assign seg_clk    = r_seg_clk;
    assign seg_dat    = r_seg_dat;
    assign seg_str    = r_seg_str;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_seg_led_scan595.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_led_scan595
// Description : Self-checking bench: 595-pair model plus latched-word scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_led_scan595;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a  = 1'b1;
    logic rst_bc = 1'b1;

    logic [31:0] dv_a  = 32'h00010203;
    logic [3:0]  raw_a = 4'h0;
    logic [3:0]  dp_a  = 4'h0;
    logic [3:0]  blk_a = 4'h0;

    logic [7:0]  dv_b  = 8'h0B;
    logic [0:0]  raw_b = 1'b0;
    logic [0:0]  dp_b  = 1'b1;
    logic [0:0]  blk_b = 1'b0;

    logic [63:0] dv_c  = 64'h0F0E0D0C0B0A0908;
    logic [7:0]  raw_c = 8'h00;
    logic [7:0]  dp_c  = 8'h00;
    logic [7:0]  blk_c = 8'h00;

    wire [2:0] o_sclk;
    wire [2:0] o_sdat;
    wire [2:0] o_sstr;
    wire [2:0] o_fd;

    seg_led_scan595 #(.DIGITS(4), .CLK_DIV(2), .SCAN_HOLD(4),
                      .SEG_ACTIVE_LOW(1'b1), .COM_ACTIVE_LOW(1'b1)) u_dut_a (
        .sys_clk(clk), .sys_rst(rst_a), .digit_val(dv_a), .raw_mode(raw_a),
        .dp(dp_a), .blank(blk_a), .seg_clk(o_sclk[0]), .seg_dat(o_sdat[0]),
        .seg_str(o_sstr[0]), .frame_done(o_fd[0]));

    seg_led_scan595 #(.DIGITS(1), .CLK_DIV(2), .SCAN_HOLD(0),
                      .SEG_ACTIVE_LOW(1'b0), .COM_ACTIVE_LOW(1'b0)) u_dut_b (
        .sys_clk(clk), .sys_rst(rst_bc), .digit_val(dv_b), .raw_mode(raw_b),
        .dp(dp_b), .blank(blk_b), .seg_clk(o_sclk[1]), .seg_dat(o_sdat[1]),
        .seg_str(o_sstr[1]), .frame_done(o_fd[1]));

    seg_led_scan595 #(.DIGITS(8), .CLK_DIV(1), .SCAN_HOLD(2),
                      .SEG_ACTIVE_LOW(1'b1), .COM_ACTIVE_LOW(1'b1)) u_dut_c (
        .sys_clk(clk), .sys_rst(rst_bc), .digit_val(dv_c), .raw_mode(raw_c),
        .dp(dp_c), .blank(blk_c), .seg_clk(o_sclk[2]), .seg_dat(o_sdat[2]),
        .seg_str(o_sstr[2]), .frame_done(o_fd[2]));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [6:0] font [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    function automatic logic [15:0] exp_word(input int d, input logic [7:0] v, input bit raw,
                                             input bit dpb, input bit blk, input bit sal, input bit cal);
        logic [7:0] s;
        logic [7:0] c;
        s = blk ? 8'h00 : (raw ? v : {dpb, font[v[3:0]]});
        c = 8'h00;
        c[d] = 1'b1;
        if (sal) s = ~s;
        if (cal) c = ~c;
        return {s, c};
    endfunction

    logic [15:0] q0 [$];
    logic [15:0] q1 [$];
    logic [15:0] q2 [$];

    function automatic int qsize(input int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic logic [15:0] qpop(input int k);
        case (k)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    task automatic push_a(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            int d;
            d = (first + i) % 4;
            q0.push_back(exp_word(d, dv_a[d*8 +: 8], raw_a[d], dp_a[d], blk_a[d], 1'b1, 1'b1));
        end
    endtask

    // 595 pair model: shift on seg_clk rise, latch on seg_str rise
    int          cyc = 0;
    logic [15:0] sr        [3];
    bit          p_clk     [3] = '{default: 1'b0};
    bit          p_str     [3] = '{default: 1'b0};
    bit          p_fd      [3] = '{default: 1'b0};
    bit          str_valid [3] = '{default: 1'b0};
    bit          fd_valid  [3] = '{default: 1'b0};
    int          last_str  [3] = '{default: 0};
    int          last_fd   [3] = '{default: 0};
    int          rise_cnt  [3] = '{default: 0};
    int          str_cnt   [3] = '{default: 0};
    int          fd_cnt    [3] = '{default: 0};
    int          dig_period   [3] = '{1 + 33*2 + 4, 1 + 33*2 + 0, 1 + 33*1 + 2};
    int          frame_period [3] = '{4 * (1 + 33*2 + 4), 1 * (1 + 33*2 + 0), 8 * (1 + 33*1 + 2)};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (o_sclk[k] && !p_clk[k]) begin
                sr[k]       <= {sr[k][14:0], o_sdat[k]};
                rise_cnt[k] <= rise_cnt[k] + 1;
            end
            if (o_sstr[k] && !p_str[k]) begin
                str_cnt[k] <= str_cnt[k] + 1;
                if (str_valid[k]) chk($sformatf("u%0d_digit_period", k), cyc - last_str[k], dig_period[k]);
                last_str[k]  <= cyc;
                str_valid[k] <= 1'b1;
                if (qsize(k) > 0) chk($sformatf("u%0d_latched_word", k), {16'h0, sr[k]}, {16'h0, qpop(k)});
            end
            if (o_fd[k]) begin
                fd_cnt[k] <= fd_cnt[k] + 1;
                chk($sformatf("u%0d_fd_single", k), {31'h0, p_fd[k]}, 0);
                if (fd_valid[k]) chk($sformatf("u%0d_frame_period", k), cyc - last_fd[k], frame_period[k]);
                last_fd[k]  <= cyc;
                fd_valid[k] <= 1'b1;
            end
            if ((k == 0) ? rst_a : rst_bc) begin
                str_valid[k] <= 1'b0;
                fd_valid[k]  <= 1'b0;
            end
            p_clk[k] <= o_sclk[k];
            p_str[k] <= o_sstr[k];
            p_fd[k]  <= o_fd[k];
        end
    end

    task automatic wait_q(input int k, input int n, input int budget);
        int t;
        t = 0;
        while ((qsize(k) > n) && (t < budget)) begin
            @(posedge clk);
            t++;
        end
        chk($sformatf("u%0d_queue_level", k), qsize(k), n);
    endtask

    task automatic wait_rises(input int k, input int n, input int budget);
        int target;
        int t;
        target = rise_cnt[k] + n;
        t = 0;
        while ((rise_cnt[k] < target) && (t < budget)) begin
            @(posedge clk);
            t++;
        end
        chk($sformatf("u%0d_rises", k), {31'h0, rise_cnt[k] >= target}, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("u%0d_rst_seg_clk", k), {31'h0, o_sclk[k]}, 0);
            chk($sformatf("u%0d_rst_seg_dat", k), {31'h0, o_sdat[k]}, 0);
            chk($sformatf("u%0d_rst_seg_str", k), {31'h0, o_sstr[k]}, 0);
            chk($sformatf("u%0d_rst_frame_done", k), {31'h0, o_fd[k]}, 0);
        end
        rst_a  = 1'b0;
        rst_bc = 1'b0;

        fork
            begin
                // basic hex, two frames
                push_a(0, 8);
                wait_q(0, 0, 2000);

                // raw, dp, blank
                dv_a  = 32'h0A0805FF;
                raw_a = 4'b0001;
                dp_a  = 4'b0010;
                blk_a = 4'b0100;
                push_a(0, 4);
                wait_q(0, 0, 1000);

                // inputs change while digit 1 is shifting
                push_a(0, 2);
                wait_q(0, 1, 1000);
                wait_rises(0, 3, 200);
                dv_a  = 32'h0C0E0907;
                raw_a = 4'b0000;
                dp_a  = 4'b0000;
                blk_a = 4'b0000;
                push_a(2, 2);
                push_a(0, 4);
                wait_q(0, 0, 1000);

                // reset in the middle of digit 0's shift
                cnt0 = str_cnt[0];
                wait_rises(0, 7, 200);
                @(negedge clk);
                rst_a = 1'b1;
                @(negedge clk);
                chk("u0_midrst_seg_clk", {31'h0, o_sclk[0]}, 0);
                chk("u0_midrst_seg_dat", {31'h0, o_sdat[0]}, 0);
                chk("u0_midrst_seg_str", {31'h0, o_sstr[0]}, 0);
                chk("u0_midrst_frame_done", {31'h0, o_fd[0]}, 0);
                chk("u0_midrst_no_strobe", str_cnt[0], cnt0);
                rst_a = 1'b0;
                push_a(0, 4);
                wait_q(0, 0, 1000);
            end
            begin
                for (int i = 0; i < 3; i++) q1.push_back(exp_word(0, dv_b, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
                wait_q(1, 0, 1000);
            end
            begin
                for (int f = 0; f < 2; f++) begin
                    for (int d = 0; d < 8; d++) begin
                        q2.push_back(exp_word(d, dv_c[d*8 +: 8], 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
                    end
                end
                wait_q(2, 0, 2000);
                repeat (10) @(posedge clk);
                chk("u2_frame_done_count", fd_cnt[2], 2);
            end
        join

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
